tx_hb_interp: RTL and testbench
===============================

# tx_hb_interp

Half-band interpolate-by-2 stage for the Tx chain, the transmit counterpart of the Rx half-band decimation stage. It uses the same tap set: odd-branch coefficients 1, -4, 13, -40, 158 (mirrored), with a centre tap of 256. Each accepted input sample produces two output samples through a polyphase structure: a 10-tap symmetric FIR phase and a pure-delay phase. Valid/ready handshakes on both sides let it sit between the Tx baseband source and the next upsampling stage.

## Interface
- DATA_W, 10: input sample width, signed two's complement.
- OUT_W, 12: output sample width, signed; must be at least DATA_W.
- C0..C4, 1 / -4 / 13 / -40 / 158: odd-branch coefficients; the branch uses C0..C4,C4..C0.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_W  input sample x[m].
- out_valid  out  1  out_data holds a sample.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  OUT_W  interpolated sample y[n].

## Operation
- Transfer rules:
  - Input transfer is in_valid && in_ready.
  - Output transfer is out_valid && out_ready.
- Delay line: taps d0..d9, each DATA_W bits. On an input transfer: d0 <= in_data, dk <= d(k-1).
- Full filter is 19 taps, h[2k] = coefficient k of the odd branch, h[9] = 256, other odd indices 0. Outputs:
  - Even phase: y[2m] = round(sum_{k=0..9} c_k * x[m-k] / 256), where x[m] is the sample just accepted and x[m-k] the older taps.
  - Odd phase: y[2m+1] = x[m-4], exactly (256*x/256). No rounding applied.
- Arithmetic:
  - Accumulator is a 20-bit signed full-precision sum (|sum c| = 432).
  - Rounding is round-half-up: (acc + 128) >>> 8.
  - Result saturates to OUT_W (±(2^(OUT_W-1)-1), min clamps to -2^(OUT_W-1)).
  - Odd-phase result is sign-extended to OUT_W.
- Phase FSM, state `phase`:
  - EVEN: out_data holds the even sample. On an output transfer, load the odd sample from the updated d4 and go to ODD.
  - ODD: out_data holds the odd sample. On an output transfer: if an input transfer happens in the same cycle, load the new even sample and go to EVEN; otherwise drop out_valid.
- in_ready = !out_valid || (phase == ODD && out_ready). This is combinational from out_ready, giving a zero-bubble input handoff.
- Even sample computation: computed combinationally from in_data and the pre-shift taps d0..d8, then registered into out_data on the accepting edge.
- Backpressure: while out_valid && !out_ready, out_data, phase and the delay line hold stable.
- in_data is ignored whenever in_ready = 0.

## Timing
- Reset values (rst high at an edge): out_valid=0, out_data=0, d0..d9=0, phase=EVEN. in_ready=1 in the cycle after reset.
- Reset mid-operation: the pending output is discarded and the history is cleared. The next output uses zero history.
- Latency: input accepted at edge t gives the even sample valid from t+1. The odd sample is valid from the edge after the even sample is consumed.
- Throughput: one input per 2 cycles with out_ready held high; output valid every cycle in steady state.
- Simultaneous ODD consume and new input: handled in one cycle with no idle cycle.
- Upstream stall: out_valid falls after the odd sample is consumed. There is no phase drift; the next input always restarts at EVEN.

## Test plan
- Impulse: in_data = 256 then 13 zeros, out_ready=1 → even outputs 1, -4, 13, -40, 158, 158, -40, 13, -4, 1, then 0; odd outputs 0,0,0,0,256,0,…; strict even/odd alternation.
- DC: 40 samples of +100, then of -512 → steady even = odd = 100, then -512. No saturation flagged at OUT_W=12.
- Rounding: impulse of 3 → even sequence 0, 0, 0, 0, 2, 2, 0, 0, 0, 0 (−40*3/256 = −0.47 rounds to 0); odd phase gives 3 at pair 4.
- Backpressure: random out_ready (50%), random in_valid → out_data stable while stalled. The output stream matches the golden 19-tap model sample-for-sample. in_ready is never high while the EVEN sample is pending.
- Reset mid-stream: assert rst for 1 cycle while phase = ODD with out_valid=1 → next cycle out_valid=0, out_data=0. A following impulse of 256 reproduces the clean impulse response.
- Saturation: OUT_W=10, alternating +511/-512 pattern aligned to the taps → even outputs clamp to +511/-512 with no wrap.

Source files
------------

// File: rtl/tx_hb_interp_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_hb_interp_if : input/output stream handshakes of the Tx half-band stage
// Rev 1.0
// ---------------------------------------------------------------------------
interface tx_hb_interp_if #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 12
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;

  // slave = the interpolator itself, master = the surrounding source/sink
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/tx_hb_interp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_hb_interp : half-band interpolate-by-2, 10-tap FIR phase + pure-delay phase
// Rev 1.0
// ---------------------------------------------------------------------------
module tx_hb_interp #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 12,
  parameter int C0     = 1,
  parameter int C1     = -4,
  parameter int C2     = 13,
  parameter int C3     = -40,
  parameter int C4     = 158
) (
  input  wire logic     clk,
  input  wire logic     rst,
  tx_hb_interp_if.slave bus
);

  localparam int NTAP  = 10;
  localparam int ACC_W = (DATA_W + 10 > OUT_W + 1) ? DATA_W + 10 : OUT_W + 1;

  localparam logic signed [ACC_W-1:0] COEF [NTAP] = '{
    ACC_W'(C0), ACC_W'(C1), ACC_W'(C2), ACC_W'(C3), ACC_W'(C4),
    ACC_W'(C4), ACC_W'(C3), ACC_W'(C2), ACC_W'(C1), ACC_W'(C0)
  };

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_e;

  phase_e                   phase_q, phase_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic signed [DATA_W-1:0] tap_q [NTAP];
  logic signed [DATA_W-1:0] tap_d [NTAP];

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [OUT_W-1:0]  even_s;
  logic signed [OUT_W-1:0]  odd_s;
  logic                     in_ready;
  logic                     in_fire;
  logic                     out_fire;

  // Even sample uses the incoming sample plus pre-shift taps d0..d8.
  always_comb begin
    acc = COEF[0] * ACC_W'(bus.in_data);
    for (int k = 1; k < NTAP; k++) begin
      acc = acc + COEF[k] * ACC_W'(tap_q[k-1]);
    end
    rnd = (acc + ACC_W'(128)) >>> 8;
    if (rnd > SAT_MAX) begin
      even_s = SAT_MAX[OUT_W-1:0];
    end else if (rnd < SAT_MIN) begin
      even_s = SAT_MIN[OUT_W-1:0];
    end else begin
      even_s = rnd[OUT_W-1:0];
    end
  end

  assign odd_s    = OUT_W'(tap_q[4]);
  // Accept a new sample while the odd sample is being consumed: no bubble.
  assign in_ready = !out_valid_q || (phase_q == ODD && bus.out_ready);
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  always_comb begin
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    tap_d       = tap_q;
    if (in_fire) begin
      tap_d[0] = bus.in_data;
      for (int k = 1; k < NTAP; k++) begin
        tap_d[k] = tap_q[k-1];
      end
      out_valid_d = 1'b1;
      out_data_d  = even_s;
      phase_d     = EVEN;
    end else if (out_fire) begin
      if (phase_q == EVEN) begin
        out_data_d = odd_s;
        phase_d    = ODD;
      end else begin
        out_valid_d = 1'b0;
        phase_d     = EVEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= EVEN;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < NTAP; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      tap_q       <= tap_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_hb_interp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tx_hb_interp : table vectors + random handshakes vs a 19-tap upsampling model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tx_hb_interp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              in_valid;
  logic signed [9:0] in_data;
  logic              out_ready;

  // Two builds share one stimulus stream: wide output and a narrow one that saturates.
  tx_hb_interp_if #(.DATA_W(10), .OUT_W(12)) a_if ();
  tx_hb_interp_if #(.DATA_W(10), .OUT_W(10)) b_if ();

  assign a_if.in_valid  = in_valid;
  assign a_if.in_data   = in_data;
  assign a_if.out_ready = out_ready;
  assign b_if.in_valid  = in_valid;
  assign b_if.in_data   = in_data;
  assign b_if.out_ready = out_ready;

  tx_hb_interp #(.DATA_W(10), .OUT_W(12)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  tx_hb_interp #(.DATA_W(10), .OUT_W(10)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int checks = 0;
  int errors = 0;
  int hist[$];
  int popped = 0;
  int cap[$];
  int bmax, bmin;

  typedef struct {
    int din;
    int ev;
    int od;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cval(input int k);
    case (k)
      0, 9: return 1;
      1, 8: return -4;
      2, 7: return 13;
      3, 6: return -40;
      default: return 158;
    endcase
  endfunction

  // Output n of the 19-tap filter applied to the zero-stuffed input stream.
  function automatic int ref_y(input int n, input int out_w);
    longint acc;
    int     h, j, hi, lo, r;
    acc = 0;
    for (int i = 0; i < 19; i++) begin
      if (i == 9) h = 256;
      else if (i % 2 == 0) h = cval(i / 2);
      else h = 0;
      j = n - i;
      if (j >= 0 && j % 2 == 0 && j / 2 < hist.size())
        acc += longint'(h) * longint'(hist[j / 2]);
    end
    r  = int'((acc + 128) >>> 8);
    hi = (1 << (out_w - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  // Scoreboard / protocol monitor, sampling on the falling edge.
  initial begin
    logic pv, pr;
    int   pda, pdb, sa, sb;
    pv = 1'b0; pr = 1'b0; pda = 0; pdb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hist.delete();
        popped = 0;
        pv     = 1'b0;
      end else begin
        sa = int'(a_if.out_data);
        sb = int'(b_if.out_data);
        if (pv && !pr) begin
          check("hold_valid", int'(a_if.out_valid), 1);
          check("hold_data_a", sa, pda);
          check("hold_data_b", sb, pdb);
        end
        check("valid_pending", int'(a_if.out_valid), int'(popped < 2 * hist.size()));
        check("valid_match_b", int'(b_if.out_valid), int'(a_if.out_valid));
        check("ready_match_b", int'(b_if.in_ready), int'(a_if.in_ready));
        if (!a_if.out_valid)
          check("ready_idle", int'(a_if.in_ready), 1);
        else if (popped % 2 == 0)
          check("ready_even_pending", int'(a_if.in_ready), 0);
        if (a_if.out_valid && out_ready) begin
          check($sformatf("data_a_n%0d", popped), sa, ref_y(popped, 12));
          check($sformatf("data_b_n%0d", popped), sb, ref_y(popped, 10));
          cap.push_back(sa);
          if (sb > bmax) bmax = sb;
          if (sb < bmin) bmin = sb;
          popped++;
        end
        if (in_valid && a_if.in_ready) hist.push_back(int'(in_data));
        pv  = a_if.out_valid;
        pr  = out_ready;
        pda = sa;
        pdb = sb;
      end
    end
  end

  task automatic send(input int x);
    int t;
    bit done;
    t = 0; done = 1'b0;
    in_valid = 1'b1;
    in_data  = 10'(x);
    while (!done) begin
      @(negedge clk);
      if (a_if.in_ready) done = 1'b1;
      @(posedge clk); #1;
      t++;
      if (!done && t > 100) begin
        check("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (popped < 2 * hist.size() && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    @(negedge clk);
    check("drain_idle", int'(a_if.out_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_table(input int first, input int n, input string tag);
    cap.delete();
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) send(tbl[first + i].din);
    drain();
    check({tag, "_len"}, cap.size(), 2 * n);
    for (int i = 0; i < n; i++) begin
      if (2 * i + 1 < cap.size()) begin
        check($sformatf("%s_even%0d", tag, i), cap[2 * i], tbl[first + i].ev);
        check($sformatf("%s_odd%0d", tag, i), cap[2 * i + 1], tbl[first + i].od);
      end
    end
  endtask

  initial begin
    int rnd_even [10];
    vec_t v;
    rnd_even = '{0, 0, 0, 0, 2, 2, 0, 0, 0, 0};
    // impulse of 256: entries 0..13
    for (int i = 0; i < 14; i++) begin
      v.din = (i == 0) ? 256 : 0;
      v.ev  = (i < 10) ? cval(i) : 0;
      v.od  = (i == 4) ? 256 : 0;
      tbl.push_back(v);
    end
    // impulse of 3: entries 14..23
    for (int i = 0; i < 10; i++) begin
      v.din = (i == 0) ? 3 : 0;
      v.ev  = rnd_even[i];
      v.od  = (i == 4) ? 3 : 0;
      tbl.push_back(v);
    end

    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst = 1'b1;
    bmax = -100000; bmin = 100000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", int'(a_if.out_valid), 0);
    check("reset_out_data", int'(a_if.out_data), 0);
    check("reset_in_ready", int'(a_if.in_ready), 1);
    @(posedge clk); #1;

    run_table(0, 14, "impulse");
    run_table(14, 10, "round");

    // DC steps
    cap.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) send(100);
    drain();
    check("dc_pos_even", cap[78], 100);
    check("dc_pos_odd", cap[79], 100);
    cap.delete();
    for (int i = 0; i < 40; i++) send(-512);
    drain();
    check("dc_neg_even", cap[78], -512);
    check("dc_neg_odd", cap[79], -512);

    // Sign-aligned full-scale patterns drive the narrow build into both clamps
    bmax = -100000; bmin = 100000;
    for (int i = 0; i < 10; i++) send(0);
    for (int k = 9; k >= 0; k--) send(cval(k) > 0 ? 511 : -512);
    for (int k = 9; k >= 0; k--) send(cval(k) > 0 ? -512 : 511);
    drain();
    check("sat_max_b", bmax, 511);
    check("sat_min_b", bmin, -512);

    // Random valid/ready against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 10'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drain();

    // Reset while the odd sample is pending and stalled
    out_ready = 1'b0;
    send(77);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", int'(a_if.out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", int'(a_if.out_valid), 0);
    check("midrst_out_data", int'(a_if.out_data), 0);
    check("midrst_out_data_b", int'(b_if.out_data), 0);
    @(posedge clk); #1;
    run_table(0, 14, "post_rst_impulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
